// File: rtl/carry_settle_adder.sv
// carry_settle_adder
//   N-bit adder split into NSEG = N/K segments of K bits. Each segment adds
//   with carry-in 0; the inter-segment carry vector is then iterated once per
//   cycle until it stops changing, so the latency tracks the longest carry
//   chain that actually occurs instead of the worst case.
//
// Ports
//   Clk        rising-edge clock
//   Rst_n      asynchronous active-low reset
//   In_valid   operands A/B/Cin present
//   In_ready   block accepts operands on this edge
//   A, B, Cin  operands and carry in
//   Out_valid  result held on S/Cout/P/Lat
//   Out_ready  consumer takes the result
//   S, Cout    registered sum and carry out
//   P          registered bitwise propagate A^B of the accepted operands
//   Lat        cycles from accept edge to Out_valid rising (1..NSEG)
module carry_settle_adder #(
    parameter int unsigned N  = 16,
    parameter int unsigned K  = 4,
    parameter int unsigned LW = $clog2(N / K + 1)
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic          In_valid,
    output logic          In_ready,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    input  logic          Cin,
    output logic          Out_valid,
    input  logic          Out_ready,
    output logic [N-1:0]  S,
    output logic          Cout,
    output logic [N-1:0]  P,
    output logic [LW-1:0] Lat
);

    localparam int unsigned NSEG = N / K;

    if ((N % K) != 0) begin : g_bad_width
        $error("carry_settle_adder: N must be a multiple of K");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e state_q, state_d;

    logic [N-1:0]    a_q, a_d, b_q, b_d, p_q, p_d, s_q, s_d;
    logic [NSEG-1:0] c_q, c_d;
    logic            cout_q, cout_d;
    logic [LW-1:0]   lat_q, lat_d, cnt_q, cnt_d;

    logic            accept;
    logic [NSEG-1:0] g_in;     // segment generates of the incoming operands
    logic [NSEG-1:0] g_reg;    // segment generates of the registered operands
    logic [NSEG-1:0] p_reg;    // segment propagates of the registered operands
    logic [NSEG-1:0] c_load;
    logic [NSEG-1:0] c_next;
    logic [N-1:0]    s_fin;
    logic            cout_fin;

    // Per-segment adders, carry-in 0
    for (genvar i = 0; i < NSEG; i++) begin : g_seg
        logic [K:0] sum_in;
        logic [K:0] sum_reg;

        assign sum_in   = {1'b0, A[i*K +: K]} + {1'b0, B[i*K +: K]};
        assign g_in[i]  = sum_in[K];
        assign sum_reg  = {1'b0, a_q[i*K +: K]} + {1'b0, b_q[i*K +: K]};
        assign g_reg[i] = sum_reg[K];
        assign p_reg[i] = &(a_q[i*K +: K] ^ b_q[i*K +: K]);
        assign s_fin[i*K +: K] = sum_reg[K-1:0] + K'(c_q[i]);
    end

    always_comb begin
        c_load    = '0;
        c_next    = '0;
        c_load[0] = Cin;
        c_next[0] = c_q[0];  // carry into segment 0 is fixed
        for (int unsigned i = 1; i < NSEG; i++) begin
            c_load[i] = g_in[i-1];
            c_next[i] = g_reg[i-1] | (p_reg[i-1] & c_q[i-1]);
        end
        cout_fin = g_reg[NSEG-1] | (p_reg[NSEG-1] & c_q[NSEG-1]);
    end

    assign accept = In_valid & In_ready;

    // State register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (accept) state_d = StCalc;
            StCalc: if (c_next == c_q) state_d = StDone;
            StDone: begin
                // A DONE-state accept retires the result and starts the next op
                if (accept) begin
                    state_d = StCalc;
                end else if (Out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs
    always_comb begin
        In_ready  = 1'b0;
        Out_valid = 1'b0;
        unique case (state_q)
            StIdle:  In_ready = 1'b1;
            StCalc:  In_ready = 1'b0;
            StDone: begin
                In_ready  = Out_ready;
                Out_valid = 1'b1;
            end
            default: In_ready = 1'b0;
        endcase
    end

    // Datapath next-state
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        s_d    = s_q;
        cout_d = cout_q;
        lat_d  = lat_q;
        if (accept) begin
            a_d   = A;
            b_d   = B;
            p_d   = A ^ B;
            c_d   = c_load;
            cnt_d = LW'(1);
        end else if (state_q == StCalc) begin
            if (c_next != c_q) begin
                c_d   = c_next;
                cnt_d = cnt_q + LW'(1);
            end else begin
                s_d    = s_fin;
                cout_d = cout_fin;
                lat_d  = cnt_q;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            c_q    <= '0;
            cnt_q  <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
            lat_q  <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            s_q    <= s_d;
            cout_q <= cout_d;
            lat_q  <= lat_d;
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign P    = p_q;
    assign Lat  = lat_q;

endmodule

// File: doc/carry_settle_adder.md
# carry_settle_adder

Clocked, parametrised successor to the combinational ripple-carry adder: an N-bit adder split into K-bit segments whose inter-segment carries settle over a data-dependent number of cycles. It completes as soon as the carries stop changing, instead of always waiting out the worst-case chain. It sits in the dynamic-adder datapath behind a valid/ready handshake on both sides. It also reports the latency it actually took, so that average-case speed can be measured in hardware.

## Interface
- N, 16, operand width; must be a multiple of K (elaboration error otherwise)
- K, 4, segment width; NSEG = N/K segments, NSEG ≥ 1
- LW, $clog2(NSEG+1), width of Lat
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous, active-low reset; one clock domain only
- In_valid  in  1  operands present
- In_ready  out  1  block can accept operands this cycle
- A, B  in  N  operands
- Cin  in  1  carry in
- Out_valid  out  1  result held on S/Cout/P/Lat
- Out_ready  in  1  consumer takes result
- S  out  N  sum
- Cout  out  1  carry out
- P  out  N  registered bitwise propagate A^B of the accepted operands
- Lat  out  LW  cycles from accept edge to Out_valid rising (1..NSEG)

## Operation
- Three states:
  - IDLE: In_ready=1, Out_valid=0.
  - CALC: both low.
  - DONE: Out_valid=1.
- Accept happens on a rising edge with In_valid & In_ready. The block registers A, B, Cin and P=A^B, then goes to CALC.
- Per segment i, computed with carry-in 0:
  - sum s_i
  - generate g_i = carry-out
  - propagate p_i = &(A_i^B_i)
- Carry vector c[0..NSEG-1]:
  - c[0]=Cin, fixed.
  - Loaded at accept with c[i]=g_{i-1} for i≥1.
- Each CALC cycle computes c_next[i] = g_{i-1} | (p_{i-1} & c[i-1]), for i≥1.
  - If c_next ≠ c: c <= c_next, stay in CALC.
  - If c_next == c: register S_i = s_i + c[i] (mod 2^K) and Cout = g_{NSEG-1} | (p_{NSEG-1} & c[NSEG-1]), load Lat, go to DONE.
- Lat is 1 plus the number of CALC cycles in which c changed. Call that count R; it equals the longest run of internal boundaries i (1..NSEG-1) whose initial c[i] differs from the true carry.
- DONE holds S, Cout, P, Lat stable until Out_ready=1.
  - Out_valid & Out_ready & !In_valid → IDLE.
  - In DONE, In_ready = Out_ready. If In_valid is also high, the result is retired and new operands are accepted on the same edge, going straight to CALC.
- Arithmetic is modular: {Cout,S} = A+B+Cin exactly. No saturation.
- NSEG=1: CALC always exits after one cycle; Lat=1.

## Timing
- Reset (asynchronous, immediate): state=IDLE, In_ready=1, Out_valid=0, S=0, Cout=0, P=0, Lat=0, internal c and operand registers=0.
- Reset asserted mid-CALC or mid-DONE: the operation is discarded and no result is produced. The first accept after release behaves as from cold.
- Latency: accept edge T0 → Out_valid high after edge T0+Lat. Best case 1 cycle, worst case NSEG cycles.
- Input changes outside an accepting edge are ignored; operands are registered.
- Outputs are registered; no combinational path from A/B/Cin to S/Cout.
- Throughput:
  - One result per Lat+1 cycles when the consumer is always ready, using the DONE→CALC back-to-back accept.
  - One result per Lat+2 cycles when a result passes through IDLE.

## Test plan
- N=16,K=4. A=0x0001, B=0x0002, Cin=0 → S=0x0003, Cout=0, P=0x0003, Lat=1; Out_valid high one edge after accept.
- A=0xFFFF, B=0x0000, Cin=1 → S=0x0000, Cout=1, P=0xFFFF, Lat=4 (full propagate chain, R=3).
- A=0x00FF, B=0x0001, Cin=0 → S=0x0100, Cout=0, Lat=2 (seg0 generates, seg1 propagates, R=1).
- Backpressure, driven in two steps:
  - Hold Out_ready=0 for 5 cycles in DONE → S/Cout/P/Lat stable, In_ready=0.
  - Then Out_ready=1 with In_valid=1 and A=0x1234, B=0x0001 → old result retired and new operands accepted on the same edge; 0x1235 appears with Lat=1.
- Start case 2, pulse Rst_n low during CALC → all outputs 0 immediately, Out_valid never rises for that op. After release, case 1 yields the correct result.
- 10000 random accepts (random In_valid/Out_ready gaps) → {Cout,S} == A+B+Cin. Lat matches a model of the carry-settle rule and lies in 1..NSEG. Repeat with K=16 (Lat always 1) and K=1 (Lat up to 16).
